// File: rtl/rgb_stream_packer_pkg.sv
// Shared types and word layout for the 24bpp RGB stream packer.
// Four pixels pack into three 32-bit words with no wasted bytes.
package rgb_stream_packer_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    // Bit position where the incoming pixel lands in the emitted word
    localparam int PH1_PIX_LSB = 24;
    localparam int PH2_PIX_LSB = 16;
    localparam int PH3_PIX_LSB = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
    } axis_entry_t;

    localparam int ENTRY_W = $bits(axis_entry_t);

    // Carry is kept low-aligned with zeros above, so an OR merges cleanly
    function automatic logic [31:0] pack_word(
        input phase_e      ph,
        input logic [23:0] px,
        input logic [23:0] carry
    );
        logic [31:0] pw;
        logic [31:0] cw;
        logic [31:0] w;
        pw = {8'h00, px};
        cw = {8'h00, carry};
        w  = '0;
        unique case (ph)
            PH1:     w = (pw << PH1_PIX_LSB) | cw;
            PH2:     w = (pw << PH2_PIX_LSB) | cw;
            PH3:     w = (pw << PH3_PIX_LSB) | cw;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rgb_stream_packer_skid.sv
// Two-entry output stage: output register plus skid register.
// Accepts up to two ordered pushes per cycle; word order is preserved.
module axis_skid_buffer
    import rgb_stream_packer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push0_i,
    input  logic [ENTRY_W-1:0] data0_i,
    input  logic               push1_i,
    input  logic [ENTRY_W-1:0] data1_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [ENTRY_W-1:0] data_o,
    output logic               skid_valid_o
);

    axis_entry_t out_q, out_d;
    axis_entry_t skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_valid_q && ready_i) begin
            out_d        = skid_q;
            out_valid_d  = skid_valid_q;
            skid_valid_d = 1'b0;
        end
        // Pushes fill the head first, then the skid slot
        if (push0_i) begin
            if (!out_valid_d) begin
                out_d       = axis_entry_t'(data0_i);
                out_valid_d = 1'b1;
            end else begin
                skid_d       = axis_entry_t'(data0_i);
                skid_valid_d = 1'b1;
            end
        end
        if (push1_i) begin
            if (!out_valid_d) begin
                out_d       = axis_entry_t'(data1_i);
                out_valid_d = 1'b1;
            end else begin
                skid_d       = axis_entry_t'(data1_i);
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign valid_o      = out_valid_q;
    assign data_o       = out_q;
    assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words for the VDMA.
// Handles sof/eol framing with flush words and a saturating error count.
module rgb_stream_packer
    import rgb_stream_packer_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter int         ERR_CNT_W = 8
) (
    input  logic                 out_stream_aclk,
    input  logic                 periph_resetn,
    input  logic [7:0]           r,
    input  logic [7:0]           g,
    input  logic [7:0]           b,
    input  logic                 valid,
    input  logic                 sof,
    input  logic                 eol,
    output logic                 in_stream_ready,
    output logic [31:0]          out_stream_tdata,
    output logic [3:0]           out_stream_tkeep,
    output logic                 out_stream_tlast,
    output logic                 out_stream_tuser,
    output logic                 out_stream_tvalid,
    input  logic                 out_stream_tready,
    output logic [ERR_CNT_W-1:0] err_count
);

    phase_e                phase_q, phase_d;
    logic [23:0]           carry_q, carry_d;
    logic                  user_q, user_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic [ERR_CNT_W:0]    err_sum;
    logic [1:0]            err_inc;

    logic [23:0]           px;
    phase_e                eff_ph;
    logic                  accept;
    logic                  dbl_req;
    logic                  out_valid;
    logic                  skid_valid;
    logic                  push0, push1;
    axis_entry_t           w0, w1, flush;
    logic [ENTRY_W-1:0]    head;
    axis_entry_t           head_e;

    assign px     = {r, g, b};
    assign eff_ph = sof ? PH0 : phase_q;

    // eol at phase 1/2 writes two words, which needs an empty output stage
    assign dbl_req = eol && (eff_ph == PH1 || eff_ph == PH2);

    assign in_stream_ready = periph_resetn && !skid_valid
                             && !(out_valid && dbl_req);
    assign accept = valid && in_stream_ready;

    always_comb begin
        flush = '0;
        flush.last = 1'b1;
        unique case (eff_ph)
            PH0:     flush.data = {PAD_BYTE, px};
            PH1:     flush.data = {PAD_BYTE, PAD_BYTE, px[23:8]};
            PH2:     flush.data = {PAD_BYTE, PAD_BYTE, PAD_BYTE, px[23:16]};
            default: flush.data = '0;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        carry_d = carry_q;
        user_d  = user_q;
        push0   = 1'b0;
        push1   = 1'b0;
        w0      = '0;
        w1      = '0;
        err_inc = 2'd0;
        if (accept) begin
            if (sof) begin
                user_d = 1'b1;
                if (phase_q != PH0) err_inc = 2'd1;
            end
            unique case (eff_ph)
                PH0: begin
                    carry_d = px;
                    phase_d = PH1;
                end
                PH1: begin
                    carry_d = {8'h00, px[23:8]};
                    phase_d = PH2;
                end
                PH2: begin
                    carry_d = {16'h0000, px[23:16]};
                    phase_d = PH3;
                end
                default: begin
                    carry_d = '0;
                    phase_d = PH0;
                end
            endcase
            if (eff_ph != PH0) begin
                push0   = 1'b1;
                w0.data = pack_word(eff_ph, px, carry_q);
                w0.user = user_q;
                user_d  = 1'b0;
            end
            if (eol) begin
                phase_d = PH0;
                carry_d = '0;
                if (eff_ph == PH3) begin
                    w0.last = 1'b1;
                end else begin
                    err_inc = err_inc + 2'd1;
                    if (eff_ph == PH0) begin
                        push0   = 1'b1;
                        w0      = flush;
                        w0.user = user_d;
                        user_d  = 1'b0;
                    end else begin
                        push1 = 1'b1;
                        w1    = flush;
                    end
                end
            end
        end
    end

    assign err_sum = {1'b0, err_q} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
    assign err_d   = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            phase_q <= PH0;
            carry_q <= '0;
            user_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            phase_q <= phase_d;
            carry_q <= carry_d;
            user_q  <= user_d;
            err_q   <= err_d;
        end
    end

    axis_skid_buffer u_skid (
        .clk_i        (out_stream_aclk),
        .rst_ni       (periph_resetn),
        .push0_i      (push0),
        .data0_i      (w0),
        .push1_i      (push1),
        .data1_i      (w1),
        .ready_i      (out_stream_tready),
        .valid_o      (out_valid),
        .data_o       (head),
        .skid_valid_o (skid_valid)
    );

    assign head_e            = axis_entry_t'(head);
    assign out_stream_tdata  = head_e.data;
    assign out_stream_tlast  = head_e.last;
    assign out_stream_tuser  = head_e.user;
    assign out_stream_tvalid = out_valid;
    assign out_stream_tkeep  = 4'hF;
    assign err_count         = err_q;

endmodule

// File: doc/rgb_stream_packer.md
Name: rgb_stream_packer

Overview:
- Sits between the fractal pixel core and the video DMA/VDMA AXI4-Stream slave.
- Accepts one 24-bit RGB pixel per handshake, with start-of-frame and end-of-line markers.
- Packs 4 pixels into 3 32-bit stream words (24 bpp, no wasted bytes).
- Drives tuser on the first word of a frame and tlast on the last word of a line, through a 2-entry skid buffer so back-pressure never drops data.

Parameters:
- PAD_BYTE, 8'h00, byte value used to fill unused bytes of a word flushed early by eol.
- ERR_CNT_W, 8, width of the saturating framing-error counter.

Ports:
- out_stream_aclk  input  1  sole clock.
- periph_resetn  input  1  asynchronous active-low reset, deasserted synchronously by the system.
- r  input  8  red of current input pixel.
- g  input  8  green.
- b  input  8  blue.
- valid  input  1  input pixel valid.
- sof  input  1  input pixel is first of frame.
- eol  input  1  input pixel is last of line.
- in_stream_ready  output  1  block accepts pixel this cycle.
- out_stream_tdata  output  32  packed word.
- out_stream_tkeep  output  4  always 4'hF.
- out_stream_tlast  output  1  last word of line.
- out_stream_tuser  output  1  first word of frame.
- out_stream_tvalid  output  1  word valid.
- out_stream_tready  input  1  downstream ready.
- err_count  output  ERR_CNT_W  saturating count of framing errors.

Behaviour:
- Pixel acceptance: a pixel is accepted when valid && in_stream_ready. in_stream_ready = !skid_valid, registered behaviour only (no combinational path from tready).
- Pixel value P = {r,g,b}, 24 bits.
- phase counter 0..3 advances by 1 per accepted pixel and wraps 3->0. A 24-bit carry register holds leftover bytes.
- Packing:
  - phase0: store P; no word emitted.
  - phase1: emit {P[7:0], P0[23:0]}; keep P[23:8].
  - phase2: emit {P[15:0], P1[23:8]}; keep P[23:16].
  - phase3: emit {P[23:0], P2[23:16]}.
- Latency: the emitted word is visible on tdata the cycle after the accepting edge when the output register is empty.
- tuser:
  - Set on the word containing the first byte of a pixel accepted with sof.
  - If sof arrives with phase != 0, the carried partial bytes are discarded (never emitted), err_count increments, and the sof pixel is packed as phase0.
- eol:
  - phase3: the word carries tlast; phase returns to 0.
  - phase0/1/2: a flush word is generated, containing the remaining valid bytes with PAD_BYTE in higher bytes and tlast=1. phase returns to 0 and err_count increments.
  - eol at phase0 emits the single pixel padded ({PAD_BYTE, P}).
  - If eol at phase1 or 2 needs two words in one cycle (normal word + flush word), both are written: output register then skid. This is permitted only when both entries are empty; otherwise in_stream_ready is held low for that pixel. Rule: in_stream_ready = !skid_valid && !(out_valid && pending_eol_double); the implementation may simply deassert ready whenever out_valid is set and phase is 1 or 2.
- Output stage:
  - out_reg/skid_reg, each holding {data, last, user}.
  - On out_stream_tready && out_stream_tvalid, skid moves to out (or out empties).
  - Word order is always preserved.
- err_count saturates at all-ones.
- Reset (async, periph_resetn low):
  - phase=0, carry=0, out_valid=0, skid_valid=0, tdata=0, tlast=0, tuser=0, tvalid=0, err_count=0.
  - in_stream_ready is 0 during reset and 1 on the first cycle after release.
  - Reset mid-line drops all partial data with no flush.
- tkeep is a constant 4'hF.

Decomposition:
- Shared package: PHASE_W=2, word layout constants (byte offsets per phase), and a struct/typedef for {data[31:0], last, user} output entries.
- One natural sub-module: axis_skid_buffer (2-entry, registered ready), reused by other stream stages.

Test Plan:
- Reset, then 4 pixels P0=0x112233, P1=0x445566, P2=0x778899, P3=0xAABBCC with sof on P0 and eol on P3, tready=1 -> words 0x66112233 (tuser=1), 0x88994455 (tuser=0), 0xAABBCC77 (tlast=1), err_count=0.
- Full 640-pixel line, tready=1 -> 480 words; tlast only on word 480; input stalls no more than the double-write rule permits.
- Same 4 pixels with tready toggling 1,0,0,1,0,1 -> identical 3 words in order, none duplicated or dropped; tvalid never drops while a word is unaccepted.
- 2 pixels 0x010203, 0x040506 with eol on the second -> words 0x06010203 then 0x00000405 (tlast=1), err_count=1.
- Pixel 0x0A0B0C, then 0x0D0E0F with sof -> the first pixel is never emitted, err_count=1, and the next word has tuser=1 with bytes 0x0D0E0F in bits [23:0].
- Assert periph_resetn low asynchronously mid-line with tvalid=1 -> tvalid=0 immediately; after release, the next line packs from phase 0 with no stale bytes.
